div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit_if.sv | 30 +++
 rtl/div_unit_sign_fix.sv | 38 +++
 rtl/div_unit.sv | 166 ++++++++++++++++
 tb/tb_div_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, result/stall bus widths.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package div_unit_pkg;

    // Default operand width; the result bus carries {remainder, quotient}.
    localparam int DIV_DATA_W   = 32;
    localparam int DIV_RESULT_W = 2 * DIV_DATA_W;

    // Pipeline stall bus: one request bit per stage, the divider stalls from EX.
    localparam int STALL_W       = 6;
    localparam int STALL_DIV_BIT = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DIVZERO = 2'd2,
        S_DONE    = 2'd3
    } div_state_e;

    // Width of the {HI, LO} result bus for a given operand width.
    function automatic int div_result_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Divider request/result bundle between the EX stage (master) and the divider (slave).
// Latency: n/a (wiring only).
// Backpressure: stallreq_for_div holds the pipeline while the divider works.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);
    localparam int RESULT_W = div_result_w(DATA_W);

    logic                start;
    logic                signed_div;
    logic [DATA_W-1:0]   opdata1;
    logic [DATA_W-1:0]   opdata2;
    logic                annul;
    logic                stallreq_for_div;
    logic                ready;
    logic [RESULT_W-1:0] result;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  stallreq_for_div, ready, result
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output stallreq_for_div, ready, result
    );

endinterface

// File: rtl/div_unit_sign_fix.sv
// Signed-divide helper: operand magnitudes and sign flags, plus negation of raw quotient/remainder.
// Latency: purely combinational.
// Backpressure: none; evaluated whenever its inputs change.
module div_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic              signed_div,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] dividend_mag,
    output logic [DATA_W-1:0] divisor_mag,
    output logic              neg_quot,
    output logic              neg_rem,
    input  logic              neg_quot_in,
    input  logic              neg_rem_in,
    input  logic [DATA_W-1:0] quot_raw,
    input  logic [DATA_W-1:0] rem_raw,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);

    logic dividend_neg;
    logic divisor_neg;

    // Magnitudes feed the unsigned core; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude and makes most-negative / -1 come out as most-negative.
    always_comb begin
        dividend_neg = signed_div & dividend[DATA_W-1];
        divisor_neg  = signed_div & divisor[DATA_W-1];
        dividend_mag = dividend_neg ? -dividend : dividend;
        divisor_mag  = divisor_neg  ? -divisor  : divisor;
        neg_quot     = dividend_neg ^ divisor_neg;
        neg_rem      = dividend_neg;
        quot         = neg_quot_in ? -quot_raw : quot_raw;
        rem          = neg_rem_in  ? -rem_raw  : rem_raw;
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle; DIV_SIGNED_EN adds signed DIV.
// Latency: DATA_W+1 cycles from start to the ready pulse (2 cycles for a zero divisor).
// Backpressure: stallreq_for_div holds the pipeline from start until the result cycle; annul aborts.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);

    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam int                RES_W     = div_result_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_e         state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [DATA_W-1:0]  rem_d, rem_q;
    logic [DATA_W-1:0]  quot_d, quot_q;
    logic [DATA_W-1:0]  divisor_d, divisor_q;
    logic [RES_W-1:0]   result_d, result_q;

    logic               accept;
    logic [DATA_W-1:0]  a_mag, b_mag;
    logic [DATA_W:0]    partial;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  step_rem, step_quot;
    logic [DATA_W-1:0]  fin_rem, fin_quot;

    // A new divide is taken only from IDLE and never in a flush cycle.
    assign accept = (state_q == S_IDLE) && bus.start && !bus.annul;

    // One restoring step: shift the next dividend bit into the partial remainder, trial-subtract.
    always_comb begin
        partial   = {rem_q, quot_q[DATA_W-1]};
        diff      = partial - {1'b0, divisor_q};
        step_rem  = diff[DATA_W] ? partial[DATA_W-1:0] : diff[DATA_W-1:0];
        step_quot = {quot_q[DATA_W-2:0], ~diff[DATA_W]};
    end

`ifdef DIV_SIGNED_EN
    logic neg_quot_d, neg_quot_q;
    logic neg_rem_d, neg_rem_q;
    logic sfx_neg_quot, sfx_neg_rem;

    div_sign_fix #(
        .DATA_W (DATA_W)
    ) u_sign_fix (
        .signed_div   (bus.signed_div),
        .dividend     (bus.opdata1),
        .divisor      (bus.opdata2),
        .dividend_mag (a_mag),
        .divisor_mag  (b_mag),
        .neg_quot     (sfx_neg_quot),
        .neg_rem      (sfx_neg_rem),
        .neg_quot_in  (neg_quot_q),
        .neg_rem_in   (neg_rem_q),
        .quot_raw     (step_quot),
        .rem_raw      (step_rem),
        .quot         (fin_quot),
        .rem          (fin_rem)
    );

    // Result sign flags are captured alongside the operands.
    always_comb begin
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        if (accept) begin
            neg_quot_d = sfx_neg_quot;
            neg_rem_d  = sfx_neg_rem;
        end
    end

    // Sign flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end
`else
    // Unsigned-only build: operands go straight to the core, signed_div has no effect.
    logic unused_signed_div;
    assign unused_signed_div = bus.signed_div;
    assign a_mag    = bus.opdata1;
    assign b_mag    = bus.opdata2;
    assign fin_quot = step_quot;
    assign fin_rem  = step_rem;
`endif

    // FSM next state and datapath updates; annul overrides everything and keeps the old result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d     = '0;
                    quot_d    = a_mag;
                    divisor_d = b_mag;
                    cnt_d     = '0;
                    state_d   = (bus.opdata2 == '0) ? S_DIVZERO : S_BUSY;
                end
            end
            S_BUSY: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d  = S_DONE;
                    result_d = {fin_rem, fin_quot};
                end
            end
            S_DIVZERO: begin
                state_d  = S_DONE;
                result_d = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (bus.annul) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    // State, iteration and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            result_q  <= result_d;
        end
    end

    // Stall is combinational so the requesting cycle itself is held; reset and flush silence it.
    assign bus.stallreq_for_div = rst && !bus.annul &&
                                  (((state_q == S_IDLE) && bus.start) ||
                                   (state_q == S_BUSY) || (state_q == S_DIVZERO));
    assign bus.ready  = (state_q == S_DONE) && !bus.annul;
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: timing, results, divide-by-zero, annul, reset.
// Latency: checks ready at DATA_W+1 cycles after start (2 for zero divisor).
// Backpressure: checks stallreq_for_div over every cycle of each divide.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [63:0] last_exp;

    div_unit_if #(.DATA_W(32)) dif ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (dif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DIV_SIGNED_EN
    localparam logic [63:0] EXP_NEG7_2   = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    localparam logic [63:0] EXP_MNEG_M1  = {32'h0000_0000, 32'h8000_0000};
    localparam logic [63:0] EXP_7_M2     = {32'h0000_0001, 32'hFFFF_FFFD};
`else
    localparam logic [63:0] EXP_NEG7_2   = {32'h0000_0001, 32'h7FFF_FFFC};
    localparam logic [63:0] EXP_MNEG_M1  = {32'h8000_0000, 32'h0000_0000};
    localparam logic [63:0] EXP_7_M2     = {32'h0000_0007, 32'h0000_0000};
`endif

    task automatic test_reset();
        rst_n          = 1'b0;
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd100;
        dif.opdata2    = 32'd7;
        dif.annul      = 1'b0;
        #2;
        n_checks++;
        if (dif.stallreq_for_div !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", dif.stallreq_for_div);
        end
        n_checks++;
        if (dif.ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0", dif.ready);
        end
        n_checks++;
        if (dif.result !== 64'h0) begin
            n_fail++; $display("FAIL reset_result: got %h expected 0", dif.result);
        end
        dif.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dif.stallreq_for_div !== 1'b0 || dif.ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got stall=%b ready=%b expected 0 0",
                               dif.stallreq_for_div, dif.ready);
        end
        last_exp = 64'h0;
    endtask

    // One divide with start held until ready; optionally disturbs operands in cycle 3.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp_res, input int exp_cyc,
                           input bit perturb);
        int   ready_cyc;
        int   stall_cnt;
        logic stall_at_ready;
        ready_cyc      = -1;
        stall_cnt      = 0;
        stall_at_ready = 1'bx;
        @(posedge clk); #1;
        dif.start      = 1'b1;
        dif.signed_div = sgn;
        dif.opdata1    = a;
        dif.opdata2    = b;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (dif.ready === 1'b1) begin
                ready_cyc      = c;
                stall_at_ready = dif.stallreq_for_div;
                dif.start      = 1'b0;
                break;
            end
            if (dif.stallreq_for_div === 1'b1) stall_cnt++;
            if (perturb && c == 3) begin
                dif.opdata1    = 32'd7;
                dif.opdata2    = 32'd7;
                dif.signed_div = ~sgn;
            end
        end
        dif.start = 1'b0;
        n_checks++;
        if (ready_cyc != exp_cyc) begin
            n_fail++; $display("FAIL %s_ready_cycle: got %0d expected %0d", name, ready_cyc, exp_cyc);
        end
        n_checks++;
        if (stall_cnt != exp_cyc) begin
            n_fail++; $display("FAIL %s_stall_cycles: got %0d expected %0d", name, stall_cnt, exp_cyc);
        end
        n_checks++;
        if (stall_at_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_stall_in_done: got %b expected 0", name, stall_at_ready);
        end
        n_checks++;
        if (dif.result !== exp_res) begin
            n_fail++; $display("FAIL %s_result: got %h expected %h", name, dif.result, exp_res);
        end
        @(negedge clk);
        n_checks++;
        if (dif.ready !== 1'b0 || dif.stallreq_for_div !== 1'b0) begin
            n_fail++; $display("FAIL %s_after_done: got ready=%b stall=%b expected 0 0",
                               name, dif.ready, dif.stallreq_for_div);
        end
        last_exp = exp_res;
    endtask

    task automatic test_annul();
        bool_wait: begin end
        @(posedge clk); #1;
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd100;
        dif.opdata2    = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        dif.annul = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dif.stallreq_for_div !== 1'b0 || dif.ready !== 1'b0) begin
            n_fail++; $display("FAIL annul_cycle10: got stall=%b ready=%b expected 0 0",
                               dif.stallreq_for_div, dif.ready);
        end
        @(posedge clk); #1;
        dif.annul = 1'b0;
        dif.start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dif.stallreq_for_div !== 1'b0) begin
            n_fail++; $display("FAIL annul_idle: got stall=%b expected 0", dif.stallreq_for_div);
        end
        begin
            int seen_ready;
            seen_ready = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (dif.ready === 1'b1 || dif.stallreq_for_div === 1'b1) seen_ready++;
            end
            n_checks++;
            if (seen_ready != 0) begin
                n_fail++; $display("FAIL annul_no_ready: got %0d active cycles expected 0", seen_ready);
            end
        end
        n_checks++;
        if (dif.result !== last_exp) begin
            n_fail++; $display("FAIL annul_result_kept: got %h expected %h", dif.result, last_exp);
        end
    endtask

    // Start held high across DONE: the next divide must begin from IDLE, not from DONE.
    task automatic test_back_to_back();
        int first_cyc;
        int second_cyc;
        logic [63:0] first_res;
        logic        stall_next;
        first_cyc  = -1;
        second_cyc = -1;
        first_res  = 64'h0;
        stall_next = 1'bx;
        @(posedge clk); #1;
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd100;
        dif.opdata2    = 32'd7;
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            if (c == first_cyc + 1 && first_cyc >= 0) stall_next = dif.stallreq_for_div;
            if (dif.ready === 1'b1) begin
                if (first_cyc < 0) begin
                    first_cyc   = c;
                    first_res   = dif.result;
                    dif.opdata1 = 32'd3;
                    dif.opdata2 = 32'd10;
                end else begin
                    second_cyc = c;
                    dif.start  = 1'b0;
                    break;
                end
            end
        end
        dif.start = 1'b0;
        n_checks++;
        if (first_cyc != 33) begin
            n_fail++; $display("FAIL b2b_first_ready: got %0d expected 33", first_cyc);
        end
        n_checks++;
        if (first_res !== {32'h0000_0002, 32'h0000_000E}) begin
            n_fail++; $display("FAIL b2b_first_result: got %h expected %h", first_res,
                               {32'h0000_0002, 32'h0000_000E});
        end
        n_checks++;
        if (stall_next !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart_stall: got %b expected 1", stall_next);
        end
        n_checks++;
        if (second_cyc != 67) begin
            n_fail++; $display("FAIL b2b_second_ready: got %0d expected 67", second_cyc);
        end
        n_checks++;
        if (dif.result !== {32'h0000_0003, 32'h0000_0000}) begin
            n_fail++; $display("FAIL b2b_second_result: got %h expected %h", dif.result,
                               {32'h0000_0003, 32'h0000_0000});
        end
        @(negedge clk);
        last_exp = {32'h0000_0003, 32'h0000_0000};
    endtask

    task automatic test_reset_mid();
        int active;
        active = 0;
        @(posedge clk); #1;
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd100;
        dif.opdata2    = 32'd7;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dif.stallreq_for_div !== 1'b0 || dif.ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got stall=%b ready=%b expected 0 0",
                               dif.stallreq_for_div, dif.ready);
        end
        n_checks++;
        if (dif.result !== 64'h0) begin
            n_fail++; $display("FAIL rst_mid_result: got %h expected 0", dif.result);
        end
        dif.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dif.ready === 1'b1 || dif.stallreq_for_div === 1'b1) active++;
        end
        n_checks++;
        if (active != 0) begin
            n_fail++; $display("FAIL rst_mid_no_ready: got %0d active cycles expected 0", active);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = 64'h0;
        test_reset();
        run_div("u100_7",   32'd100,        32'd7,          1'b0, {32'h0000_0002, 32'h0000_000E}, 33, 1'b0);
        run_div("s_neg7_2", 32'hFFFF_FFF9,  32'h0000_0002,  1'b1, EXP_NEG7_2,                     33, 1'b0);
        run_div("div0",     32'd5,          32'd0,          1'b0, 64'h0,                          2,  1'b0);
        run_div("s_mneg",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, EXP_MNEG_M1,                    33, 1'b0);
        run_div("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, EXP_7_M2,                       33, 1'b0);
        run_div("u_neg7_2", 32'hFFFF_FFF9,  32'h0000_0002,  1'b0, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 1'b0);
        run_div("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33, 1'b0);
        run_div("u3_10",    32'd3,          32'd10,         1'b0, {32'h0000_0003, 32'h0000_0000}, 33, 1'b0);
        run_div("busy_ign", 32'd1000,       32'd10,         1'b0, {32'h0000_0000, 32'h0000_0064}, 33, 1'b1);
        test_annul();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
